// File: rtl/ov7670_stream_gen.sv
// Emulates an OV7670 camera output: divided pixel clock, vsync/href framing and
// a selectable test pattern presented one byte per pclk period.
`timescale 1ns/1ps
module ov7670_stream_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   parameter int CLK_DIV     = 2
) (
   input  logic        clk24,
   input  logic        rst_n,
   input  logic        run,
   input  logic [1:0]  mode,
   input  logic [7:0]  pattern_value,
   output logic        pclk,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  dout,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int LB  = 2 * (H_ACTIVE + H_BLANK);
   localparam int FL  = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int VS0 = VSYNC_LINES + V_BACK;
   localparam int HW  = (LB > 1) ? $clog2(LB) : 1;
   localparam int VW  = (FL > 1) ? $clog2(FL) : 1;
   localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(LB - 1);
   localparam logic [VW-1:0] V_LAST = VW'(FL - 1);
   localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          pclk_q, pclk_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic [1:0]    mode_q, mode_d;
   logic [7:0]    actCnt_q, actCnt_d;
   logic          vsync_q, vsync_d;
   logic          href_q, href_d;
   logic [7:0]    dout_q, dout_d;
   logic          frameDone_q, frameDone_d;
   logic [15:0]   frameCnt_q, frameCnt_d;

   logic          tick;
   logic          startFrame;
   logic [7:0]    actBase;
   logic [31:0]   hExt, vExt, yPix;

   // Slot outputs are computed for the slot being entered, so they land on the pclk falling edge.
   always_comb begin
      div_d       = (div_q == D_LAST) ? '0 : div_q + DW'(1);
      tick        = (div_q == D_LAST);
      pclk_d      = (div_d >= D_HALF);
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      vcnt_d      = vcnt_q;
      mode_d      = mode_q;
      actCnt_d    = actCnt_q;
      vsync_d     = vsync_q;
      href_d      = href_q;
      dout_d      = dout_q;
      frameDone_d = 1'b0;
      frameCnt_d  = frameCnt_q;
      startFrame  = 1'b0;
      actBase     = actCnt_q;
      hExt        = '0;
      vExt        = '0;
      yPix        = '0;

      if (tick) begin
         case (state_q)
            IDLE: begin
               if (run) begin
                  state_d    = ACTIVE;
                  startFrame = 1'b1;
               end
            end
            ACTIVE: begin
               if (hcnt_q == H_LAST && vcnt_q == V_LAST) begin
                  frameDone_d = 1'b1;
                  frameCnt_d  = frameCnt_q + 16'd1;
                  hcnt_d      = '0;
                  vcnt_d      = '0;
                  if (run) startFrame = 1'b1;
                  else     state_d    = IDLE;
               end else if (hcnt_q == H_LAST) begin
                  hcnt_d = '0;
                  vcnt_d = vcnt_q + VW'(1);
               end else begin
                  hcnt_d = hcnt_q + HW'(1);
               end
            end
            default: state_d = IDLE;
         endcase

         if (startFrame) begin
            hcnt_d  = '0;
            vcnt_d  = '0;
            mode_d  = mode;
            actBase = '0;
         end

         hExt     = 32'(hcnt_d);
         vExt     = 32'(vcnt_d);
         yPix     = vExt - 32'(VS0);
         vsync_d  = 1'b0;
         href_d   = 1'b0;
         dout_d   = 8'h00;
         actCnt_d = actBase;

         if (state_d == ACTIVE) begin
            vsync_d = (vExt < 32'(VSYNC_LINES));
            href_d  = (vExt >= 32'(VS0)) && (yPix < 32'(V_ACTIVE)) &&
                      (hExt < 32'(2 * H_ACTIVE));
            if (href_d) begin
               actCnt_d = actBase + 8'd1;
               case (mode_d)
                  2'd0:    dout_d = actBase;
                  2'd1:    dout_d = hExt[0] ? yPix[8:1] : hExt[10:3];
                  2'd2:    dout_d = (hExt[4] ^ yPix[3]) ? 8'hFF : 8'h00;
                  default: dout_d = pattern_value;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk24) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         div_q       <= '0;
         pclk_q      <= 1'b0;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         mode_q      <= 2'd0;
         actCnt_q    <= 8'd0;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         dout_q      <= 8'h00;
         frameDone_q <= 1'b0;
         frameCnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         pclk_q      <= pclk_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         mode_q      <= mode_d;
         actCnt_q    <= actCnt_d;
         vsync_q     <= vsync_d;
         href_q      <= href_d;
         dout_q      <= dout_d;
         frameDone_q <= frameDone_d;
         frameCnt_q  <= frameCnt_d;
      end
   end

   assign pclk       = pclk_q;
   assign vsync      = vsync_q;
   assign href       = href_q;
   assign dout       = dout_q;
   assign busy       = (state_q == ACTIVE);
   assign frame_done = frameDone_q;
   assign frame_cnt  = frameCnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: randomized run/mode/pattern stimulus on a reduced
// frame geometry, compared every clk24 cycle against a slot-index reference model.
`timescale 1ns/1ps
module tb_ov7670_stream_gen;

   localparam int HA   = 16;
   localparam int VA   = 12;
   localparam int HB   = 4;
   localparam int VSL  = 2;
   localparam int VBK  = 2;
   localparam int VFR  = 2;
   localparam int CDIV = 4;
   localparam int LB   = 2 * (HA + HB);
   localparam int FL   = VSL + VBK + VA + VFR;
   localparam int VS0  = VSL + VBK;
   localparam int FRAME_SLOTS = LB * FL;

   logic        clk24 = 1'b0;
   logic        rst_n;
   logic        run;
   logic [1:0]  mode;
   logic [7:0]  pattern_value;
   logic        pclk, vsync, href, busy, frame_done;
   logic [7:0]  dout;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: frame position kept as a single slot index.
   bit   mActive;
   int   mSlot, mMode, mActCnt, mFrames;
   int   expVsync, expHref, expDout, expDone;

   bit          runWant, patRandom;
   logic [1:0]  modeWant;
   logic [7:0]  patFixed;

   ov7670_stream_gen #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VSL),
      .V_BACK(VBK), .V_FRONT(VFR), .CLK_DIV(CDIV)
   ) dut (
      .clk24(clk24), .rst_n(rst_n), .run(run), .mode(mode),
      .pattern_value(pattern_value), .pclk(pclk), .vsync(vsync), .href(href),
      .dout(dout), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 clk24 = ~clk24;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkSlotOutputs(input string phase);
      checkOutput({phase, "_vsync"}, 32'(vsync), 32'(expVsync));
      checkOutput({phase, "_href"}, 32'(href), 32'(expHref));
      checkOutput({phase, "_dout"}, 32'(dout), 32'(expDout));
      checkOutput({phase, "_busy"}, 32'(busy), 32'(mActive));
      checkOutput({phase, "_frame_cnt"}, 32'(frame_cnt), 32'(mFrames % 65536));
   endtask

   task automatic modelTick(input bit r, input int m, input int pv);
      int line, b, x, y;
      expDone = 0;
      if (!mActive) begin
         if (r) begin
            mActive = 1; mSlot = 0; mMode = m; mActCnt = 0;
         end
      end else if (mSlot == FRAME_SLOTS - 1) begin
         expDone = 1;
         mFrames++;
         if (r) begin
            mSlot = 0; mMode = m; mActCnt = 0;
         end else begin
            mActive = 0;
         end
      end else begin
         mSlot++;
      end
      expVsync = 0; expHref = 0; expDout = 0;
      if (mActive) begin
         line = mSlot / LB;
         b    = mSlot % LB;
         x    = b / 2;
         y    = line - VS0;
         expVsync = (line < VSL) ? 1 : 0;
         expHref  = (line >= VS0 && line < VS0 + VA && b < 2 * HA) ? 1 : 0;
         if (expHref == 1) begin
            case (mMode)
               0: begin expDout = mActCnt % 256; mActCnt++; end
               1: expDout = (b % 2 == 0) ? (x / 4) % 256 : (y / 2) % 256;
               2: expDout = (((x / 8) + (y / 8)) % 2 == 1) ? 255 : 0;
               default: expDout = pv;
            endcase
         end
      end
   endtask

   // One byte slot: drive inputs, check hold between edges, then check the new slot.
   task automatic applyStimulus();
      bit midFrame;
      midFrame = mActive && (mSlot != FRAME_SLOTS - 1);
      run  = midFrame ? 1'($urandom_range(0, 1)) : runWant;
      mode = midFrame ? 2'($urandom_range(0, 3)) : modeWant;
      pattern_value = patRandom ? 8'($urandom_range(0, 255)) : patFixed;
      for (int k = 1; k < CDIV; k++) begin
         @(posedge clk24); #1;
         checkOutput("pclk_phase", 32'(pclk), (k >= CDIV / 2) ? 32'd1 : 32'd0);
         checkOutput("done_low", 32'(frame_done), 32'd0);
         checkSlotOutputs("hold");
      end
      @(posedge clk24); #1;
      modelTick(run, int'(mode), int'(pattern_value));
      checkOutput("pclk_fall", 32'(pclk), 32'd0);
      checkOutput("frame_done", 32'(frame_done), 32'(expDone));
      checkSlotOutputs("slot");
   endtask

   task automatic runSlots(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_pclk"}, 32'(pclk), 32'd0);
      checkOutput({tag, "_vsync"}, 32'(vsync), 32'd0);
      checkOutput({tag, "_href"}, 32'(href), 32'd0);
      checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
   endtask

   task automatic modelReset();
      mActive = 0; mSlot = 0; mMode = 0; mActCnt = 0; mFrames = 0;
      expVsync = 0; expHref = 0; expDout = 0; expDone = 0;
   endtask

   // Reset asserted for one clk24 edge at an arbitrary phase within a slot.
   task automatic resetPulse();
      int j;
      j = $urandom_range(0, CDIV - 2);
      repeat (j) @(posedge clk24);
      #1 rst_n = 1'b0;
      @(posedge clk24); #1;
      checkResetState("pulse");
      modelReset();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; mode = 2'd0; pattern_value = 8'h00;
      runWant = 1'b0; modeWant = 2'd0; patRandom = 1'b1; patFixed = 8'h00;
      modelReset();
      repeat (3) @(posedge clk24);
      #1;
      checkResetState("reset");
      rst_n = 1'b1;

      // Counting pattern across two complete frames and into a third.
      runWant = 1'b1; modeWant = 2'd0;
      runSlots(1 + 2 * FRAME_SLOTS);

      // Checkerboard frame.
      modeWant = 2'd2;
      runSlots(FRAME_SLOTS);

      // Constant byte 0xA5, then coordinate pattern while mode toggles mid-frame.
      modeWant = 2'd3; patRandom = 1'b0; patFixed = 8'hA5;
      runSlots(FRAME_SLOTS);
      modeWant = 2'd1; patRandom = 1'b1;
      runSlots(FRAME_SLOTS);

      // Stop request: current frame completes, then the block idles.
      runWant = 1'b0;
      runSlots(FRAME_SLOTS + 20);

      // Restart, abort mid-frame with reset, and run a fresh frame.
      runWant = 1'b1; modeWant = 2'($urandom_range(0, 3));
      runSlots(FRAME_SLOTS / 2);
      resetPulse();
      runSlots(FRAME_SLOTS + 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ov7670_stream_gen.md
OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter H_BLANK, default 144, meaning blank pixels per line.
REQ-004 The block SHALL have parameters VSYNC_LINES (3), V_BACK (17) and V_FRONT (10), meaning the vsync-high lines, the lines after vsync before active video, and the lines after active video.
REQ-005 The block SHALL have parameter CLK_DIV, default 2, meaning clk24 cycles per pclk period; it SHALL be even and at least 2.
REQ-006 Ports SHALL be:
- clk24 input 1: the only clock.
- rst_n input 1: synchronous, active-low reset.
- run input 1: request frame generation.
- mode input 2: pattern select.
- pattern_value input 8: constant byte used by mode 3.
- pclk output 1: emulated camera pixel clock.
- vsync output 1: camera vertical sync.
- href output 1: camera horizontal reference.
- dout output 8: camera data byte.
- busy output 1: a frame is in progress.
- frame_done output 1: one-cycle pulse at the end of a frame.
- frame_cnt output 16: count of completed frames.

Function
REQ-007 The block SHALL define a byte slot as one pclk period; each pixel SHALL occupy 2 byte slots.
REQ-008 The line length SHALL be LB = 2*(H_ACTIVE+H_BLANK) slots (1568 at defaults). The frame length SHALL be FL = VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT lines (510 at defaults).
REQ-009 pclk SHALL be low for CLK_DIV/2 clk24 cycles and then high for CLK_DIV/2 cycles, free-running whenever rst_n=1. Slot outputs SHALL change only on the clk24 edge where pclk falls, so that they are stable at the pclk rising edge.
REQ-010 The block SHALL hold byte counter hcnt (0..LB-1) and line counter vcnt (0..FL-1). Both SHALL advance once per slot. hcnt SHALL wrap to 0 after LB-1 and increment vcnt; vcnt SHALL wrap to 0 after FL-1.
REQ-011 The state machine SHALL have exactly two states, IDLE and ACTIVE.
REQ-012 IDLE -> ACTIVE: at a pclk-falling edge with run=1. On that edge hcnt=vcnt=0, the outputs for slot (0,0) SHALL be presented, and mode SHALL be latched into mode_q.
REQ-013 In ACTIVE, run SHALL be sampled only at frame end. At the final slot (hcnt=LB-1, vcnt=FL-1): with run=1 the block SHALL continue directly into the next frame with slot (0,0) and re-latch mode; with run=0 it SHALL go to IDLE.
REQ-014 The block SHALL ignore run=0 mid-frame; the frame SHALL always complete.
REQ-015 vsync SHALL be 1 iff ACTIVE and vcnt<VSYNC_LINES.
REQ-016 href SHALL be 1 iff ACTIVE, VS0 <= vcnt < VS0+V_ACTIVE, and hcnt<2*H_ACTIVE, where VS0 = VSYNC_LINES+V_BACK (20).
REQ-017 Pixel coordinates SHALL be x = hcnt>>1 and y = vcnt-VS0.
REQ-018 dout SHALL be 0 whenever href=0.
REQ-019 When href=1, dout SHALL follow mode_q:
- 0: low 8 bits of the count of active bytes already emitted in this frame (starts at 0, increments each href slot).
- 1: x[9:2] on even hcnt, y[8:1] on odd hcnt.
- 2: 0xFF if (x[3]^y[3])=1, else 0x00.
- 3: pattern_value, sampled each slot.
REQ-020 A change of mode mid-frame SHALL NOT affect the current frame.
REQ-021 busy SHALL be 1 iff the state is ACTIVE.
REQ-022 frame_done SHALL pulse high for exactly one clk24 cycle on the edge that leaves the final slot of a frame.
REQ-023 frame_cnt SHALL increment on that same edge and SHALL wrap from 0xFFFF to 0.
REQ-024 In IDLE, vsync=href=0 and dout=0; pclk SHALL keep toggling.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from an input to an output.

Reset
REQ-026 When rst_n=0 at a clk24 edge, the block SHALL force state IDLE, hcnt=vcnt=0, the divider=0, pclk=0, vsync=0, href=0, dout=0, busy=0, frame_done=0, frame_cnt=0 and mode_q=0.
REQ-027 Reset mid-frame SHALL abort the frame without asserting frame_done. After release, the first pclk fall SHALL occur CLK_DIV clk24 cycles later.

Verification
REQ-028 Reset, then hold run=1 with mode=0 at defaults: vsync high for 3*1568 slots; first href on line 20; 1280 href slots per line; dout sequence 0x00,0x01,...,0xFF,0x00; frame_done once every 510*1568 slots.
REQ-029 Frame in mode=2 at defaults: byte slots for pixel (8,0) = 0xFF,0xFF; pixel (8,8) = 0x00,0x00; pixel (0,0) = 0x00,0x00.
REQ-030 Set run=0 at line 100 of frame 1: the frame completes, frame_cnt=1, busy falls on the same edge as frame_done, then vsync/href stay 0.
REQ-031 Change mode from 3 (pattern_value=0xA5) to 1 mid-frame: every active byte of the current frame = 0xA5; the next frame uses mode 1 (pixel (4,2) bytes = 0x01, 0x01).
REQ-032 Pulse rst_n low for 1 cycle during line 300: all outputs are 0 the next cycle, frame_cnt=0, no frame_done pulse, and a fresh frame starts from vsync if run=1.
REQ-033 Sample at each pclk rising edge with CLK_DIV=4: vsync, href and dout never change within 2 clk24 cycles of the rising edge.
